hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- Producer side of the writeback HI/LO sources: an iterative multiply/divide unit that owns the architectural HI and LO registers.
- Sits beside the EX-stage ALU. Its outputs feed the HI/LO inputs of the writeback data select, so MFHI/MFLO read them.
- Takes MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX. Raises busy so the hazard unit stalls any HI/LO consumer or new muldiv op.

Parameters:
- W, 32, operand width; HI and LO are W bits each. The iteration count equals W.

Ports:
- clk  in  1  core clock, rising edge
- resetn  in  1  asynchronous reset, active-low
- valid_i  in  1  EX instruction is a HI/LO op and is not stalled
- op_i  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-op
- rs_i  in  W  operand A: multiplicand / dividend / MT source
- rt_i  in  W  operand B: multiplier / divisor
- flush_i  in  1  exception/eret flush; cancels an in-flight op
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle pulse on the edge that HI/LO take a muldiv result
- hi_o  out  W  architectural HI
- lo_o  out  W  architectural LO

Behaviour:
- Reset (async, resetn=0): state=IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, counter=0. An op in flight is discarded.
- States: IDLE, RUN, FIX.
- IDLE accept, edge E, with valid_i=1 and flush_i=0:
  - MULT/MULTU/DIV/DIVU go to RUN. At this edge: latch |rs| and |rt| (magnitudes only for signed ops), latch the sign bits, latch the op, set counter=W-1, clear the 2W accumulator.
  - MTHI: hi_o<=rs_i at E, stay IDLE. MTLO: lo_o<=rs_i at E, stay IDLE. Neither raises busy.
- RUN: one iteration per edge, E+1..E+W. Exits to FIX when counter==0, otherwise counter decrements.
  - Multiply: shift-add radix-2 on magnitudes into the 2W product.
  - Divide: restoring shift-subtract on magnitudes, producing a W-bit quotient and a W-bit remainder.
- FIX at edge E+W+1: write hi_o/lo_o, pulse done_o, return to IDLE.
  - Multiply: {hi,lo} = product, two's-complement negated if signed and sign A != sign B.
  - Divide: lo = quotient, negated if signed and signs differ. hi = remainder, negated if signed and sign A is 1.
  - Divisor zero (detected at accept): lo=all-ones, hi=raw rs_i. This holds for DIV and DIVU; sign fix is bypassed.
  - Signed 0x80000000 / -1: lo=0x80000000, hi=0 (natural wrap, no trap).
- busy_o is high for W+1 cycles, after edge E through edge E+W+1. New HI/LO are visible the cycle after edge E+W+1.
- valid_i while busy: ignored. The pipeline guarantees a stall; no queueing.
- flush_i=1:
  - In RUN/FIX: go to IDLE next edge, no HI/LO write, no done_o pulse.
  - In IDLE: suppresses accept of that cycle's op, including MTHI/MTLO.
- Back-to-back: a new op may be accepted on the first IDLE cycle after FIX.
- HI/LO hold their value when not written.
- Op codes 110/111 with valid_i: no effect.

Decomposition:
- Shared package: op-code constants (OP_MULT..OP_MTLO), state encoding, W default.
- One natural sub-module, muldiv_iter_core: the shift-add/shift-subtract datapath and counter. Interface: load/step/last, magnitude in, raw product/quotient/remainder out.
- hilo_muldiv keeps the FSM, sign handling, HI/LO registers and flush logic.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy 33 cycles, done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Also MTHI 0x12345678, then MTLO 0x9ABCDEF0 next cycle -> both visible one edge later, busy stays 0.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=100, rt=7 -> LO=0x0000000E, HI=0x00000002.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU rs=0x55, rt=0 -> LO=0xFFFFFFFF, HI=0x55.
- Cancellation and stalls:
  - flush_i at RUN cycle 10 of DIVU -> IDLE next edge; HI/LO keep prior values (preload with MTHI/MTLO); no done pulse.
  - valid_i held during busy with a second op -> ignored.
- Async reset mid-RUN with clk stopped -> busy_o, hi_o, lo_o go to 0 immediately.
  - After release, MULTU 3×4 -> HI=0, LO=12.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   W_DEF   : default operand width (HI and LO are W_DEF bits each)
//   OP_*    : 3-bit HI/LO operation codes presented by EX
//   state_t : control FSM states
package hilo_muldiv_pkg;

  localparam int unsigned W_DEF = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Iterative ops: multiply/divide in signed or unsigned flavour.
  function automatic logic is_muldiv(input logic [2:0] op);
    return op[2] == 1'b0;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// EX-side bus of the HI/LO multiply/divide unit.
//   valid_i, op_i, rs_i, rt_i, flush_i : request from EX (master drives)
//   busy_o, done_o, hi_o, lo_o         : status and architectural HI/LO (slave drives)
interface hilo_muldiv_if #(
  parameter int unsigned W = 32
);
  logic         valid_i;
  logic [2:0]   op_i;
  logic [W-1:0] rs_i;
  logic [W-1:0] rt_i;
  logic         flush_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  modport master (
    output valid_i, op_i, rs_i, rt_i, flush_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  valid_i, op_i, rs_i, rt_i, flush_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply / restoring divide on
// unsigned magnitudes, one iteration per step_i, W iterations per op.
//   clk, resetn : clock, async active-low reset
//   load_i      : latch magnitudes/op, counter=W-1, clear accumulator
//   step_i      : perform one iteration
//   div_i       : 1 = divide, 0 = multiply (sampled with load_i)
//   a_i, b_i    : magnitude A (multiplicand/dividend), B (multiplier/divisor)
//   last_o      : counter is 0, current step is the final one
//   prod_o      : raw 2W product
//   quot_o      : raw quotient, rem_o : raw remainder
module muldiv_iter_core
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           div_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           last_o,
  output logic [2*W-1:0] prod_o,
  output logic [W-1:0]   quot_o,
  output logic [W-1:0]   rem_o
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  logic           div_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] acc_q;
  logic [CW-1:0]  cnt_q;

  logic [W:0] mul_sum;
  logic [W:0] div_shift;
  logic [W:0] div_diff;
  logic       div_ge;

  // Multiply: the multiplier drains LSB-first out of b_q while product bits
  // shift into the bottom of acc_q. Divide: dividend bits leave a_q MSB-first,
  // the remainder lives in the top half and quotient bits enter the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (b_q[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_q[2*W-1:W], a_q[W-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = ~div_diff[W];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      div_q <= div_i;
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
      cnt_q <= CW'(W - 1);
    end else if (step_i) begin
      if (div_q) begin
        acc_q <= {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ge};
        a_q   <= {a_q[W-2:0], 1'b0};
      end else begin
        acc_q <= {mul_sum, acc_q[W-1:1]};
        b_q   <= {1'b0, b_q[W-1:1]};
      end
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == '0);
  assign prod_o = acc_q;
  assign quot_o = acc_q[W-1:0];
  assign rem_o  = acc_q[2*W-1:W];

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit owning architectural HI and LO.
//   clk, resetn : core clock, async active-low reset
//   bus (slave) : valid_i/op_i/rs_i/rt_i/flush_i from EX;
//                 busy_o (state != IDLE), done_o (result-write pulse), hi_o, lo_o
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  hilo_muldiv_if.slave bus
);

  state_t       state_q;
  logic         busy_q;
  logic         done_q;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;
  logic         signed_q;
  logic         sa_q;
  logic         sb_q;
  logic         dz_q;
  logic [W-1:0] rs_raw_q;

  logic           accept;
  logic           load;
  logic           step;
  logic           op_signed;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic           last;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix;
  logic [W-1:0]   rem_fix;

  always_comb begin
    accept    = (state_q == ST_IDLE) && bus.valid_i && !bus.flush_i;
    load      = accept && is_muldiv(bus.op_i);
    step      = (state_q == ST_RUN) && !bus.flush_i;
    op_signed = ~bus.op_i[0];
    mag_a     = (op_signed && bus.rs_i[W-1]) ? (~bus.rs_i + 1'b1) : bus.rs_i;
    mag_b     = (op_signed && bus.rt_i[W-1]) ? (~bus.rt_i + 1'b1) : bus.rt_i;
    prod_fix  = (signed_q && (sa_q ^ sb_q)) ? (~prod + 1'b1) : prod;
    quot_fix  = (signed_q && (sa_q ^ sb_q)) ? (~quot + 1'b1) : quot;
    rem_fix   = (signed_q && sa_q) ? (~rem + 1'b1) : rem;
  end

  muldiv_iter_core #(.W(W)) u_core (
    .clk    (clk),
    .resetn (resetn),
    .load_i (load),
    .step_i (step),
    .div_i  (bus.op_i[1]),
    .a_i    (mag_a),
    .b_i    (mag_b),
    .last_o (last),
    .prod_o (prod),
    .quot_o (quot),
    .rem_o  (rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      signed_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      rs_raw_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (bus.op_i)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state_q  <= ST_RUN;
                busy_q   <= 1'b1;
                signed_q <= op_signed;
                sa_q     <= bus.rs_i[W-1];
                sb_q     <= bus.rt_i[W-1];
                dz_q     <= bus.op_i[1] && (bus.rt_i == '0);
                rs_raw_q <= bus.rs_i;
              end
              OP_MTHI: hi_q <= bus.rs_i;
              OP_MTLO: lo_q <= bus.rs_i;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (bus.flush_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (last) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (!bus.flush_i) begin
            done_q <= 1'b1;
            // The core ran the op in its own latched mode; dz_q implies divide.
            if (dz_q) begin
              hi_q <= rs_raw_q;
              lo_q <= '1;
            end else if (u_core.div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  bit   clk_en = 1'b1;

  hilo_muldiv_if #(.W(32)) bus ();

  hilo_muldiv #(.W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int unsigned npass = 0;
  int unsigned ntot  = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = '0;
    lo = '0;
    case (op)
      3'b000: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'b001: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      3'b010: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin p = sa / sb; lo = p[31:0]; p = sa % sb; hi = p[31:0]; end
      end
      3'b011: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
      end
      default: ;
    endcase
  endtask

  // Caller is at a negedge. Returns at the negedge after the result edge.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit hold);
    int unsigned cyc;
    bit          done_seen;
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.rs_i    = a;
    bus.rt_i    = b;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      bus.op_i = OP_MTHI;
      bus.rs_i = 32'hDEADBEEF;
    end else begin
      bus.valid_i = 1'b0;
    end
    cyc       = 0;
    done_seen = 1'b0;
    while (bus.busy_o && cyc < 200) begin
      if (bus.done_o) done_seen = 1'b1;
      cyc++;
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    chk({name, " busy_cycles"}, 64'(cyc), 64'd33);
    chk({name, " early_done"}, 64'(done_seen), 64'd0);
    chk({name, " done"}, 64'(bus.done_o), 64'd1);
    chk({name, " hi"}, 64'(bus.hi_o), 64'(exp_hi));
    chk({name, " lo"}, 64'(bus.lo_o), 64'(exp_lo));
  endtask

  initial begin
    logic [31:0] ehi, elo, ra, rb;
    logic [2:0]  rop;
    int unsigned sel;
    bit          done_seen;

    bus.valid_i = 1'b0;
    bus.op_i    = 3'b111;
    bus.rs_i    = '0;
    bus.rt_i    = '0;
    bus.flush_i = 1'b0;

    #12;
    chk("reset busy", 64'(bus.busy_o), 64'd0);
    chk("reset done", 64'(bus.done_o), 64'd0);
    chk("reset hi", 64'(bus.hi_o), 64'd0);
    chk("reset lo", 64'(bus.lo_o), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // MTHI then MTLO on consecutive cycles
    bus.valid_i = 1'b1; bus.op_i = OP_MTHI; bus.rs_i = 32'h12345678;
    @(negedge clk);
    chk("mthi hi", 64'(bus.hi_o), 64'h12345678);
    chk("mthi busy", 64'(bus.busy_o), 64'd0);
    bus.op_i = OP_MTLO; bus.rs_i = 32'h9ABCDEF0;
    @(negedge clk);
    bus.valid_i = 1'b0;
    chk("mtlo lo", 64'(bus.lo_o), 64'h9ABCDEF0);
    chk("mtlo busy", 64'(bus.busy_o), 64'd0);

    // No-op codes and flush in IDLE leave HI/LO untouched
    bus.valid_i = 1'b1; bus.op_i = 3'b110; bus.rs_i = 32'hFFFFFFFF;
    @(negedge clk);
    bus.op_i = 3'b111;
    @(negedge clk);
    bus.op_i = OP_MTHI; bus.flush_i = 1'b1;
    @(negedge clk);
    bus.op_i = OP_MULTU; bus.rt_i = 32'd3;
    @(negedge clk);
    bus.valid_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    chk("noop busy", 64'(bus.busy_o), 64'd0);
    chk("noop hi", 64'(bus.hi_o), 64'h12345678);
    chk("noop lo", 64'(bus.lo_o), 64'h9ABCDEF0);

    // Directed vectors, issued back-to-back
    tbl[0] = '{"mult_neg3x5",  OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    tbl[1] = '{"multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[2] = '{"div_neg7by2",  OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{"divu_100by7",  OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    tbl[4] = '{"div_ovf",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[5] = '{"divu_by0",     OP_DIVU,  32'h00000055, 32'd0,        32'h00000055, 32'hFFFFFFFF};
    tbl[6] = '{"div_neg_by0",  OP_DIV,   32'h80000005, 32'd0,        32'h80000005, 32'hFFFFFFFF};
    tbl[7] = '{"mult_minsq",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[8] = '{"div_7byneg2",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    for (int i = 0; i < 9; i++)
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", 64'(bus.done_o), 64'd0);

    // Flush during RUN: prior HI/LO survive, no done pulse
    bus.valid_i = 1'b1; bus.op_i = OP_MTHI; bus.rs_i = 32'hAAAA5555;
    @(negedge clk);
    bus.op_i = OP_MTLO; bus.rs_i = 32'h13579BDF;
    @(negedge clk);
    bus.op_i = OP_DIVU; bus.rs_i = 32'd1000; bus.rt_i = 32'd3;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush pre busy", 64'(bus.busy_o), 64'd1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush busy", 64'(bus.busy_o), 64'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_o || bus.busy_o) done_seen = 1'b1;
      @(negedge clk);
    end
    chk("flush no_done", 64'(done_seen), 64'd0);
    chk("flush hi", 64'(bus.hi_o), 64'hAAAA5555);
    chk("flush lo", 64'(bus.lo_o), 64'h13579BDF);

    // Second op held on valid_i while busy is ignored
    run_op("hold_multu", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = '0;
      else if (sel == 1) rb = $urandom_range(1, 15);
      else if (sel == 2) begin ra = 32'h80000000; rb = '1; end
      model(rop, ra, rb, ehi, elo);
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, ehi, elo, 1'b0);
    end

    // Async reset mid-RUN with the clock stopped
    @(negedge clk);
    bus.valid_i = 1'b1; bus.op_i = OP_MTHI; bus.rs_i = 32'h11112222;
    @(negedge clk);
    bus.op_i = OP_MULT; bus.rs_i = 32'd7; bus.rt_i = 32'd9;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (5) @(negedge clk);
    clk_en = 1'b0;
    #3;
    chk("prereset busy", 64'(bus.busy_o), 64'd1);
    resetn = 1'b0;
    #1;
    chk("async busy", 64'(bus.busy_o), 64'd0);
    chk("async hi", 64'(bus.hi_o), 64'd0);
    chk("async lo", 64'(bus.lo_o), 64'd0);
    chk("async done", 64'(bus.done_o), 64'd0);
    #5;
    resetn = 1'b1;
    #2;
    clk_en = 1'b1;
    @(negedge clk);
    run_op("post_reset_multu", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
